// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } state_t;

  // Per-line status bits; tag and block storage are parameter-sized and kept beside it.
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_flags_t;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned words,
                                        input int unsigned sets);
    return addr_w - 2 - $clog2(words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU ages: victim is the lowest invalid way, otherwise the oldest way.
module cache_lru
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 2,
  parameter int unsigned WAYS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic [WAYS-1:0]         valid_vec,
  output logic [$clog2(WAYS)-1:0] victim,
  input  logic                    upd_en,
  input  logic [$clog2(WAYS)-1:0] upd_way
);

  localparam int unsigned WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic             found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(WAYS - 1 - w);
        end
      end
    end else if (upd_en) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          age_q[set_idx][w] <= '0;
        end else if (age_q[set_idx][w] < age_q[set_idx][upd_way]) begin
          age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) begin
          victim = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with valid/ready CPU and memory ports.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 2,
  parameter int unsigned WAYS   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_rw,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_resp_valid,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_hit,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_rw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W*WORDS-1:0]   mem_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W*WORDS-1:0]   mem_rdata
);

  localparam int unsigned OFF_W = off_w(WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, WORDS, SETS);
  localparam int unsigned WAY_W = way_w(WAYS);
  localparam int unsigned BLK_W = DATA_W * WORDS;

  state_t state_q, state_d;

  logic              req_rw_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [WAY_W-1:0]  way_q;

  line_flags_t       flags_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAYS-1:0]   valid_vec;
  logic [WAY_W-1:0]  victim;
  logic              victim_dirty;
  logic [DATA_W-1:0] fill_word;

  assign req_off = req_addr_q[2 +: OFF_W];
  assign req_idx = req_addr_q[2 + OFF_W +: IDX_W];
  assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      valid_vec[w] = flags_q[req_idx][w].valid;
      if (flags_q[req_idx][w].valid && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    victim_dirty = flags_q[req_idx][victim].valid && flags_q[req_idx][victim].dirty;
  end

  always_comb begin
    fill_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (OFF_W'(w) == req_off) begin
        fill_word = mem_rdata[BLK_W-1-w*DATA_W -: DATA_W];
      end
    end
  end

  cache_lru #(
    .SETS(SETS),
    .WAYS(WAYS)
  ) u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_idx  (req_idx),
    .valid_vec(valid_vec),
    .victim   (victim),
    .upd_en   (state_q == RESP),
    .upd_way  (way_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)               state_d = RESP;
        else if (victim_dirty) state_d = WB_REQ;
        else                   state_d = FILL_REQ;
      end
      WB_REQ:    if (mem_req_ready) state_d = FILL_REQ;
      FILL_REQ:  if (mem_req_ready) state_d = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Memory-side outputs derive only from state and storage that cannot change until
  // the request is accepted, so they hold steady across back-pressure.
  always_comb begin
    cpu_req_ready  = (state_q == IDLE);
    cpu_resp_valid = (state_q == RESP);
    mem_req_valid  = (state_q == WB_REQ) || (state_q == FILL_REQ);
    mem_rw         = (state_q == WB_REQ);
    mem_addr       = '0;
    mem_wdata      = '0;
    if (state_q == WB_REQ) begin
      mem_addr = {tag_q[req_idx][way_q], req_idx, {(OFF_W + 2){1'b0}}};
      for (int unsigned w = 0; w < WORDS; w++) begin
        mem_wdata[BLK_W-1-w*DATA_W -: DATA_W] = data_q[req_idx][way_q][w];
      end
    end else if (state_q == FILL_REQ) begin
      mem_addr = {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      way_q       <= '0;
      cpu_rdata   <= '0;
      cpu_hit     <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          flags_q[s][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            req_rw_q    <= cpu_rw;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
          end
        end
        LOOKUP: begin
          cpu_hit <= hit;
          if (hit) begin
            way_q     <= hit_way;
            cpu_rdata <= data_q[req_idx][hit_way][req_off];
            if (req_rw_q) flags_q[req_idx][hit_way].dirty <= 1'b1;
          end else begin
            way_q <= victim;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            flags_q[req_idx][way_q] <= line_flags_t'{valid: 1'b1, dirty: req_rw_q};
            cpu_rdata               <= fill_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && req_rw_q) begin
      data_q[req_idx][hit_way][req_off] <= req_wdata_q;
    end
    if (state_q == FILL_WAIT && mem_resp_valid) begin
      tag_q[req_idx][way_q] <= req_tag;
      for (int unsigned w = 0; w < WORDS; w++) begin
        data_q[req_idx][way_q][w] <= (req_rw_q && OFF_W'(w) == req_off)
                                     ? req_wdata_q
                                     : mem_rdata[BLK_W-1-w*DATA_W -: DATA_W];
      end
    end
  end

endmodule

// File: doc/cache_nway_wb.md
# cache_nway_wb

Parametrised, clocked N-way set-associative write-back, write-allocate data cache between the CPU load/store path and block-wide main memory. Successor to the combinational 2-way cache: sets, ways, block size and address width are parameters; both the CPU and memory sides use valid/ready handshakes; a registered FSM sequences lookup, write-back and refill; replacement is invalid-first, then true LRU.

## Interface
- ADDR_W, 10, byte-address width
- DATA_W, 32, word width
- WORDS, 4, words per block (power of 2, ≥2)
- SETS, 2, number of sets (power of 2, ≥2)
- WAYS, 2, associativity (power of 2, ≥2)
- Derived: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-2-OFF_W-IDX_W; BLK_W=DATA_W*WORDS
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  cache can accept (IDLE only)
- cpu_rw  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  byte address: [1:0] byte, then word offset, index, tag (MSBs)
- cpu_wdata  in  DATA_W  store data
- cpu_resp_valid  out  1  one-cycle pulse: request complete
- cpu_rdata  out  DATA_W  load data, valid with cpu_resp_valid on reads
- cpu_hit  out  1  1 if the completed request hit, valid with cpu_resp_valid
- mem_req_valid  out  1  memory request present
- mem_req_ready  in  1  memory accepts request
- mem_rw  out  1  1=block write-back, 0=block read
- mem_addr  out  ADDR_W  block-aligned address (low OFF_W+2 bits zero)
- mem_wdata  out  BLK_W  write-back block; word w at bits [BLK_W-1-w*DATA_W -: DATA_W] (word 0 at MSBs)
- mem_resp_valid  in  1  read block returned
- mem_rdata  in  BLK_W  refill block, same word packing

## Operation
- Line state per set/way: valid, dirty, tag, block; LRU age per way (log2(WAYS) bits).
- States: IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESP.
- IDLE: cpu_req_ready=1; on valid&ready latch rw/addr/wdata → LOOKUP.
- LOOKUP: compare tag across all ways of set. Hit → perform read/write on hit way, write sets dirty, → RESP. Miss → victim = lowest-index invalid way, else way with age WAYS-1; victim dirty → WB_REQ, else FILL_REQ.
- WB_REQ: mem_rw=1, mem_addr={victim tag, index, 0}, mem_wdata=victim block; on mem_req_ready → FILL_REQ (write completes on accept, no response).
- FILL_REQ: mem_rw=0, mem_addr={req tag, index, 0}; on mem_req_ready → FILL_WAIT.
- FILL_WAIT: on mem_resp_valid install block, valid=1, dirty=0, tag=req tag; then apply request (write merges cpu_wdata into word, dirty=1; read selects word) → RESP.
- RESP: cpu_resp_valid=1, cpu_hit=hit flag from LOOKUP, cpu_rdata=word (writes: rdata holds previous value); update LRU: accessed way age 0, ways with smaller age +1; → IDLE.
- Reset values: state IDLE, all valid/dirty 0, way i age = WAYS-1-i, cpu_req_ready=1, cpu_resp_valid=0, cpu_rdata=0, cpu_hit=0, mem_req_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0.

## Timing
- Hit: accept at edge E0, LOOKUP cycle, cpu_resp_valid high the cycle after E1; next accept earliest 3 cycles after E0.
- Miss: hit latency + memory handshake cycles; clean miss one request, dirty miss write then read, never overlapped.
- mem_req_valid, mem_rw, mem_addr, mem_wdata stable from assertion until accepted; mem_req_valid drops the cycle after acceptance.
- cpu_req_valid outside IDLE ignored; mem_resp_valid outside FILL_WAIT ignored.
- rst_n low at any time (incl. mid-write-back/fill): all outputs to reset values immediately; dirty data discarded; in-flight request dropped, no response.

## Structure
- Package cache_pkg: state enum, width helper functions (OFF_W/IDX_W/TAG_W), line-state struct.
- Sub-module cache_lru: per-set age array, victim select (invalid-first, then oldest), age update on access.

## Test plan (defaults: index=addr[4], tag=addr[9:5])
- Reset, read 0x000, memory returns {A,B,C,D} → one mem read at 0x000, rdata=A, hit=0; then read 0x004 → hit=1, rdata=B, resp 2 cycles after accept, no mem traffic.
- Write 0x008=0xDEADBEEF after fill → hit=1, no mem traffic; read 0x008 → 0xDEADBEEF.
- Read 0x000, read 0x020, read 0x000, read 0x040 → 0x040 replaces way holding 0x020; read 0x000 still hits.
- Write 0x020=0x12345678 (miss, allocate), evict via 0x000 then 0x040 → mem write at 0x020, word 0=0x12345678, precedes read at 0x040.
- mem_req_ready low 5 cycles during fill → mem_req_valid/mem_addr stable, cpu_req_ready=0, no response until accept.
- rst_n low in FILL_WAIT → outputs at reset values, no cpu_resp_valid; re-read same address misses.
